// File: rtl/secuenciador_pkg.sv
// Shared types and helpers for the serial bit-chain reducer.
// The optional early-exit build is selected with SECUENCIADOR_EARLY_EXIT_EN
// in secuenciador_cadena.sv; this package is the same in both builds.
package secuenciador_pkg;

   // Controller states. IDLE accepts work, CALC walks the word, DONE holds the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } estado_t;

   // Two-input operation applied by the shared cell.
   typedef enum logic [1:0] {
      OP_AND = 2'd0,
      OP_OR  = 2'd1,
      OP_XOR = 2'd2
   } op_t;

   // Identity element of the operation: the accumulator starts here.
   function automatic logic identidad(input op_t op);
      return (op == OP_AND) ? 1'b1 : 1'b0;
   endfunction

   // True when the accumulator can no longer change for this operation
   // (0 for AND, 1 for OR). XOR has no absorbing value.
   function automatic logic es_absorbente(input op_t op, input logic acc);
      case (op)
         OP_AND:  return ~acc;
         OP_OR:   return acc;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/celda_op.sv
// Single two-input combinational cell; the operation is fixed by OP.
module celda_op
   import secuenciador_pkg::*;
#(
   parameter op_t OP = OP_AND
) (
   input  logic a,
   input  logic b,
   output logic q
);

   // Apply the selected operation to the two inputs.
   always_comb begin
      case (OP)
         OP_AND:  q = a & b;
         OP_OR:   q = a | b;
         default: q = a ^ b;
      endcase
   end

endmodule

// File: rtl/secuenciador_cadena.sv
// Serial bit-chain reducer: one shared celda_op folds the word LSB-first,
// one bit per clock, and hands the 1-bit result out through valid/ack.
// Handshake: a word is taken on an edge where start=1 and ready=1; the
// result is offered while valid=1 and released on an edge where ack=1.
// ready/busy/valid are a one-hot decode of the controller state, so they
// double as the state observation point.
// Optional macro SECUENCIADOR_EARLY_EXIT_EN: leave CALC as soon as the
// accumulator reaches an absorbing value (AND -> 0, OR -> 1). The result
// is the same either way; only the latency shrinks.
module secuenciador_cadena
   import secuenciador_pkg::*;
#(
   parameter int  ANCHO = 8,
   parameter op_t OP    = OP_AND
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ANCHO-1:0] dato,
   output logic             ready,
   output logic             busy,
   output logic             valid,
   output logic             resultado,
   input  logic             ack
);

   localparam int            CW     = $clog2(ANCHO + 1);
   localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);
   localparam logic          INIT   = identidad(OP);

   estado_t          state_q, state_d;
   logic [ANCHO-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             acc_q, acc_d;
   logic             res_q, res_d;
   logic             acc_cell;
   logic             salida_temprana;

   // The one shared cell: folds the current LSB into the accumulator.
   celda_op #(.OP(OP)) u_celda (
      .a (acc_q),
      .b (shreg_q[0]),
      .q (acc_cell)
   );

`ifdef SECUENCIADOR_EARLY_EXIT_EN
   assign salida_temprana = es_absorbente(OP, acc_cell);
`else
   assign salida_temprana = 1'b0;
`endif

   // State and datapath registers; reset aborts any run in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         acc_q   <= 1'b0;
         res_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
      end
   end

   // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               shreg_d = dato;
               acc_d   = INIT;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d   = acc_cell;
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            // The last bit (or an absorbing value) finishes the run.
            if ((cnt_q == ULTIMO) || salida_temprana) begin
               res_d   = acc_cell;
               state_d = DONE;
            end
         end
         DONE: begin
            // start is deliberately ignored here: no back-to-back acceptance.
            if (ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ready     = (state_q == IDLE);
   assign busy      = (state_q == CALC);
   assign valid     = (state_q == DONE);
   assign resultado = res_q;

endmodule

// File: tb/tb_secuenciador_cadena.sv
// Self-checking bench for secuenciador_cadena: four instances
// (AND/8, OR/8, XOR/8, AND/1) driven by directed and random transactions
// and compared against a bit-counting reference model.
module tb_secuenciador_cadena;
   import secuenciador_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] start_v = '0;
   logic [3:0] ack_v = '0;
   wire  [3:0] ready_v, busy_v, valid_v, res_v;
   logic [7:0] dato0 = '0, dato1 = '0, dato2 = '0;
   logic       dato3 = 1'b0;

   int         n_vec = 0;
   int         n_err = 0;
   logic [0:0] exp_q[$];
   int         lat_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   secuenciador_cadena #(.ANCHO(8), .OP(OP_AND)) u_and8 (
      .clk(clk), .rst(rst), .start(start_v[0]), .dato(dato0), .ready(ready_v[0]),
      .busy(busy_v[0]), .valid(valid_v[0]), .resultado(res_v[0]), .ack(ack_v[0]));
   secuenciador_cadena #(.ANCHO(8), .OP(OP_OR)) u_or8 (
      .clk(clk), .rst(rst), .start(start_v[1]), .dato(dato1), .ready(ready_v[1]),
      .busy(busy_v[1]), .valid(valid_v[1]), .resultado(res_v[1]), .ack(ack_v[1]));
   secuenciador_cadena #(.ANCHO(8), .OP(OP_XOR)) u_xor8 (
      .clk(clk), .rst(rst), .start(start_v[2]), .dato(dato2), .ready(ready_v[2]),
      .busy(busy_v[2]), .valid(valid_v[2]), .resultado(res_v[2]), .ack(ack_v[2]));
   secuenciador_cadena #(.ANCHO(1), .OP(OP_AND)) u_and1 (
      .clk(clk), .rst(rst), .start(start_v[3]), .dato(dato3), .ready(ready_v[3]),
      .busy(busy_v[3]), .valid(valid_v[3]), .resultado(res_v[3]), .ack(ack_v[3]));

   // ---------------- reference model ----------------
   function automatic int ancho_de(input int u);
      return (u == 3) ? 1 : 8;
   endfunction

   function automatic op_t op_de(input int u);
      case (u)
         1:       return OP_OR;
         2:       return OP_XOR;
         default: return OP_AND;
      endcase
   endfunction

   function automatic logic ref_res(input int u, input logic [7:0] d);
      int w;
      int ones;
      w = ancho_de(u);
      ones = 0;
      for (int i = 0; i < w; i++) if (d[i]) ones++;
      case (op_de(u))
         OP_AND:  return (ones == w);
         OP_OR:   return (ones > 0);
         default: return ((ones % 2) == 1);
      endcase
   endfunction

   function automatic int ref_lat(input int u, input logic [7:0] d);
      int w;
      w = ancho_de(u);
`ifdef SECUENCIADOR_EARLY_EXIT_EN
      for (int i = 0; i < w; i++) begin
         if (op_de(u) == OP_AND && !d[i]) return i + 1;
         if (op_de(u) == OP_OR && d[i]) return i + 1;
      end
`endif
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_dato(input int u, input logic [7:0] d);
      case (u)
         0:       dato0 = d;
         1:       dato1 = d;
         2:       dato2 = d;
         default: dato3 = d[0];
      endcase
   endtask

   // One full transaction: accept, wait for valid (bounded), hold, ack.
   task automatic run_txn(input int u, input logic [7:0] d, input int hold,
                          output bit ready_fell, output int busy_n, output int lat,
                          output logic res, output bit stable, output logic ready_after);
      @(negedge clk);
      set_dato(u, d);
      start_v[u] = 1'b1;
      @(posedge clk);
      #1;
      ready_fell = !ready_v[u];
      @(negedge clk);
      start_v[u] = 1'b0;
      set_dato(u, ~d);
      lat = 0;
      busy_n = 0;
      while (!valid_v[u] && lat < 40) begin
         if (busy_v[u]) busy_n++;
         @(posedge clk);
         #1;
         lat++;
      end
      res = res_v[u];
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (!valid_v[u] || res_v[u] !== res) stable = 1'b0;
      end
      @(negedge clk);
      ack_v[u] = 1'b1;
      @(posedge clk);
      #1;
      ready_after = ready_v[u];
      @(negedge clk);
      ack_v[u] = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      #2;
      for (int u = 0; u < 4; u++) begin
         n_vec++;
         if ({ready_v[u], busy_v[u], valid_v[u], res_v[u]} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_u%0d: rdy/busy/val/res=%b want 1000", u,
                     {ready_v[u], busy_v[u], valid_v[u], res_v[u]});
         end
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_and_full();
      bit rf, st;
      int bn, lat;
      logic r, ra;
      run_txn(0, 8'hFF, 3, rf, bn, lat, r, st, ra);
      n_vec++;
      if (rf !== 1'b1) begin n_err++; $display("FAIL and_ff_ready_fall: ready_fell=%0b want 1", rf); end
      n_vec++;
      if (bn !== 8) begin n_err++; $display("FAIL and_ff_busy_cycles: got %0d want 8", bn); end
      n_vec++;
      if (lat !== 8) begin n_err++; $display("FAIL and_ff_latency: got %0d want 8", lat); end
      n_vec++;
      if (r !== 1'b1) begin n_err++; $display("FAIL and_ff_result: got %0b want 1", r); end
      n_vec++;
      if (st !== 1'b1) begin n_err++; $display("FAIL and_ff_hold: valid/result not stable"); end
      n_vec++;
      if (ra !== 1'b1) begin n_err++; $display("FAIL and_ff_ready_after_ack: got %0b want 1", ra); end
   endtask

   task automatic test_and_early();
      bit rf, st;
      int bn, lat;
      logic r, ra;
      run_txn(0, 8'hFE, 1, rf, bn, lat, r, st, ra);
      n_vec++;
      if (lat !== ref_lat(0, 8'hFE)) begin
         n_err++;
         $display("FAIL and_fe_latency: got %0d want %0d", lat, ref_lat(0, 8'hFE));
      end
      n_vec++;
      if (r !== 1'b0) begin n_err++; $display("FAIL and_fe_result: got %0b want 0", r); end
   endtask

   task automatic test_xor();
      bit rf, st;
      int bn, lat;
      logic r, ra;
      run_txn(2, 8'h07, 0, rf, bn, lat, r, st, ra);
      n_vec++;
      if (r !== 1'b1 || lat !== 8) begin
         n_err++;
         $display("FAIL xor_07: result=%0b lat=%0d want 1 and 8", r, lat);
      end
      run_txn(2, 8'h03, 2, rf, bn, lat, r, st, ra);
      n_vec++;
      if (r !== 1'b0 || lat !== 8) begin
         n_err++;
         $display("FAIL xor_03: result=%0b lat=%0d want 0 and 8", r, lat);
      end
   endtask

   task automatic test_or_ignore();
      int lat;
      int held;
      @(negedge clk);
      set_dato(1, 8'h00);
      start_v[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[1] = 1'b0;
      set_dato(1, 8'hFF);
      lat = 0;
      while (!valid_v[1] && lat < 40) begin
         start_v[1] = (lat == 2);
         ack_v[1] = (lat == 4);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      start_v[1] = 1'b0;
      ack_v[1] = 1'b0;
      n_vec++;
      if (lat !== 8 || res_v[1] !== 1'b0) begin
         n_err++;
         $display("FAIL or_ignore_run: lat=%0d result=%0b want 8 and 0", lat, res_v[1]);
      end
      held = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (valid_v[1] && res_v[1] === 1'b0) held++;
      end
      n_vec++;
      if (held !== 5) begin n_err++; $display("FAIL or_valid_hold: held %0d cycles want 5", held); end
      @(negedge clk);
      ack_v[1] = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      ack_v[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({ready_v[1], busy_v[1], valid_v[1]} !== 3'b100) begin
         n_err++;
         $display("FAIL or_single_result: rdy/busy/val=%b want 100", {ready_v[1], busy_v[1], valid_v[1]});
      end
   endtask

   task automatic test_reset_mid_calc();
      bit rf, st;
      int bn, lat;
      logic r, ra;
      @(negedge clk);
      set_dato(0, 8'hFF);
      start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_vec++;
      if (busy_v[0] !== 1'b1) begin n_err++; $display("FAIL mid_calc_busy: got %0b want 1", busy_v[0]); end
      #1;
      rst = 1'b1;
      #1;
      n_vec++;
      if ({ready_v[0], busy_v[0], valid_v[0], res_v[0]} !== 4'b1000) begin
         n_err++;
         $display("FAIL async_reset: rdy/busy/val/res=%b want 1000",
                  {ready_v[0], busy_v[0], valid_v[0], res_v[0]});
      end
      @(negedge clk);
      rst = 1'b0;
      run_txn(0, 8'hFF, 0, rf, bn, lat, r, st, ra);
      n_vec++;
      if (lat !== 8 || r !== 1'b1) begin
         n_err++;
         $display("FAIL after_reset_run: lat=%0d result=%0b want 8 and 1", lat, r);
      end
   endtask

   task automatic test_ancho1();
      bit rf, st;
      int bn, lat;
      logic r, ra;
      run_txn(3, 8'h00, 1, rf, bn, lat, r, st, ra);
      n_vec++;
      if (lat !== 1 || r !== 1'b0 || bn !== 1) begin
         n_err++;
         $display("FAIL ancho1_zero: lat=%0d busy=%0d result=%0b want 1,1,0", lat, bn, r);
      end
      @(negedge clk);
      set_dato(3, 8'h01);
      start_v[3] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[3] = 1'b0;
      lat = 0;
      while (!valid_v[3] && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      n_vec++;
      if (lat !== 1 || res_v[3] !== 1'b1) begin
         n_err++;
         $display("FAIL ancho1_one: lat=%0d result=%0b want 1 and 1", lat, res_v[3]);
      end
      start_v[3] = 1'b1;
      ack_v[3] = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if ({ready_v[3], busy_v[3], valid_v[3]} !== 3'b100) begin
         n_err++;
         $display("FAIL start_ack_done: rdy/busy/val=%b want 100", {ready_v[3], busy_v[3], valid_v[3]});
      end
      @(negedge clk);
      start_v[3] = 1'b0;
      ack_v[3] = 1'b0;
      @(posedge clk);
      #1;
      n_vec++;
      if ({ready_v[3], busy_v[3], valid_v[3], res_v[3]} !== 4'b1001) begin
         n_err++;
         $display("FAIL no_new_run: rdy/busy/val/res=%b want 1001",
                  {ready_v[3], busy_v[3], valid_v[3], res_v[3]});
      end
   endtask

   task automatic test_random();
      bit rf, st;
      int bn, lat, u, hold, lat_exp;
      logic r, ra;
      logic [7:0] d;
      logic [0:0] res_exp;
      for (int n = 0; n < 40; n++) begin
         u = $urandom_range(0, 3);
         d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) d = 8'hFF;
         hold = $urandom_range(0, 3);
         exp_q.push_back(ref_res(u, d));
         lat_q.push_back(ref_lat(u, d));
         run_txn(u, d, hold, rf, bn, lat, r, st, ra);
         res_exp = exp_q.pop_front();
         lat_exp = lat_q.pop_front();
         n_vec++;
         if (r !== res_exp[0] || lat !== lat_exp || st !== 1'b1 || ra !== 1'b1 || rf !== 1'b1) begin
            n_err++;
            $display("FAIL random_u%0d_d%02h: res=%0b lat=%0d stable=%0b rdy_fall=%0b rdy_after=%0b want res=%0b lat=%0d 1 1 1",
                     u, d, r, lat, st, rf, ra, res_exp[0], lat_exp);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_and_full();
      test_and_early();
      test_xor();
      test_or_ignore();
      test_reset_mid_calc();
      test_ancho1();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
